// File: rtl/reg_wb_queue.sv
// In-order write-back queue feeding the register file write port, with two forwarding lookups.
// Optional drop counter for writes to r0/r15 is enabled by defining REG_WB_DROP_STATS_EN.
module reg_wb_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          in_addr,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       stall,
    input  logic                       flush,
    output logic                       w,
    output logic [ADDR_W-1:0]          dr_addr,
    output logic [DATA_W-1:0]          d_in,
    input  logic [ADDR_W-1:0]          fwd1_addr,
    output logic                       fwd1_hit,
    output logic [DATA_W-1:0]          fwd1_data,
    input  logic [ADDR_W-1:0]          fwd2_addr,
    output logic                       fwd2_hit,
    output logic [DATA_W-1:0]          fwd2_data,
`ifdef REG_WB_DROP_STATS_EN
    output logic [7:0]                 drop_cnt,
`endif
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic              w_accept;
    logic              w_read_only;
    logic              w_push;
    logic              w_pop;
    logic [PTR_W-1:0]  w_idx;

    // r0 is the zero register and r15 (all ones) holds the core ID; neither is writable.
    assign w_read_only = (in_addr == '0) || (&in_addr);
    assign in_ready    = (r_count < CNT_W'(DEPTH)) && !flush;
    assign w_accept    = in_valid && in_ready;
    assign w_push      = w_accept && !w_read_only;

    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign w       = !empty && !stall && !flush;
    assign w_pop   = w;
    assign dr_addr = empty ? '0 : r_addr[r_head];
    assign d_in    = empty ? '0 : r_data[r_head];

    // NOTE: the queue storage is reset explicitly so a stale head never leaks onto the write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_addr[r_tail] <= in_addr;
                r_data[r_tail] <= in_data;
                r_tail         <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Walk oldest to youngest so a later match overwrites an earlier one.
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        fwd1_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_hit  = 1'b0;
        fwd2_data = '0;
        w_idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PTR_W'(i);
            if (CNT_W'(i) < r_count) begin
                if ((r_addr[w_idx] == fwd1_addr) && (fwd1_addr != '0) && !(&fwd1_addr)) begin
                    fwd1_hit  = 1'b1;
                    fwd1_data = r_data[w_idx];
                end
                if ((r_addr[w_idx] == fwd2_addr) && (fwd2_addr != '0) && !(&fwd2_addr)) begin
                    fwd2_hit  = 1'b1;
                    fwd2_data = r_data[w_idx];
                end
            end
        end
    end

`ifdef REG_WB_DROP_STATS_EN
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_accept && w_read_only && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule
